// File: rtl/cp_remove.sv
// rtl/cp_remove.sv - cyclic-prefix removal ahead of the FFT; optional long CP on symbol 0 via CP_LONG_EN
module cp_remove #(
    parameter int N            = 2048,
    parameter int CP_LEN       = 144,
    parameter int CP_EXTRA     = 16,
    parameter int SYM_PER_HALF = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        valid_in,
    input  logic        sof_in,
    output logic [15:0] dout,
    output logic        valid_out,
    output logic        first_out,
    output logic        last_out,
    output logic [2:0]  sym_idx,
    output logic        sync_err
);

    localparam int              CW       = $clog2(N + CP_LEN + CP_EXTRA);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam logic [2:0]      SYM_LAST = 3'(SYM_PER_HALF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        PASS = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      sym_q;
    logic [15:0]     dout_q;
    logic            valid_q;
    logic            first_q;
    logic            last_q;
    logic [2:0]      sym_out_q;
    logic            err_q;

    logic [CW-1:0]   cp_last;
    logic            sof_expected;

    // Index of the final CP sample of the current symbol (long CP only on symbol 0)
    always_comb begin
`ifdef CP_LONG_EN
        cp_last = (sym_q == 3'd0) ? CW'(CP_LEN + CP_EXTRA - 1) : CW'(CP_LEN - 1);
`else
        cp_last = CW'(CP_LEN - 1);
`endif
        sof_expected = (state_q == SKIP) && (cnt_q == '0) && (sym_q == 3'd0);
    end

    // Symbol framing FSM with registered outputs; advances only on accepted samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sym_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            sym_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            if (valid_in) begin
                if (sof_in) begin
                    // sof always (re)starts symbol 0; it is only an error away from its expected slot
                    err_q   <= (state_q != IDLE) && !sof_expected;
                    state_q <= SKIP;
                    cnt_q   <= CW'(1);
                    sym_q   <= '0;
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            state_q <= IDLE;
                        end
                        SKIP: begin
                            if (cnt_q == cp_last) begin
                                state_q <= PASS;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        PASS: begin
                            dout_q    <= din;
                            valid_q   <= 1'b1;
                            first_q   <= (cnt_q == '0);
                            last_q    <= (cnt_q == CNT_LAST);
                            sym_out_q <= sym_q;
                            if (cnt_q == CNT_LAST) begin
                                state_q <= SKIP;
                                cnt_q   <= '0;
                                sym_q   <= (sym_q == SYM_LAST) ? 3'd0 : sym_q + 3'd1;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            sym_q   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_q;
    assign first_out = first_q;
    assign last_out  = last_q;
    assign sym_idx   = sym_out_q;
    assign sync_err  = err_q;

endmodule

// File: tb/tb_cp_remove.sv
// tb/tb_cp_remove.sv - directed table-driven bench for cp_remove
module tb_cp_remove;

    localparam int N    = 16;
    localparam int CP   = 4;
    localparam int SYMS = 7;
`ifdef CP_LONG_EN
    localparam int CPX  = 2;
`else
    localparam int CPX  = 0;
`endif
    localparam int H    = SYMS * (N + CP) + CPX;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = '0;
    logic        valid_in = 1'b0;
    logic        sof_in = 1'b0;
    logic [15:0] dout;
    logic        valid_out;
    logic        first_out;
    logic        last_out;
    logic [2:0]  sym_idx;
    logic        sync_err;

    int total = 0;
    int bad   = 0;

    cp_remove #(
        .N(N), .CP_LEN(CP), .CP_EXTRA(2), .SYM_PER_HALF(SYMS)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .valid_in(valid_in), .sof_in(sof_in),
        .dout(dout), .valid_out(valid_out), .first_out(first_out),
        .last_out(last_out), .sym_idx(sym_idx), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit v;
        int dout;
        bit f;
        bit l;
        int s;
    } exp_t;

    int lv [0:199];
    int ld [0:199];
    int lf [0:199];
    int ll [0:199];
    int ls [0:199];
    int le [0:199];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [15:0] d);
        valid_in = v;
        sof_in   = s;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        din      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic record(input int d);
        lv[d] = int'(valid_out);
        ld[d] = int'(dout);
        lf[d] = int'(first_out);
        ll[d] = int'(last_out);
        ls[d] = int'(sym_idx);
        le[d] = int'(sync_err);
    endtask

    // Expected output for a ramp whose only sof is at sample 0 (first half-subframe)
    task automatic exp_of(input int d, output bit v, output bit f, output bit l, output int s);
        int q, off, r;
        q = d % H;
        if (q < CP + CPX + N) begin
            off = q - (CP + CPX);
            s   = 0;
        end else begin
            r   = q - (CP + CPX + N);
            s   = 1 + r / (N + CP);
            off = (r % (N + CP)) - CP;
        end
        v = (off >= 0);
        f = (off == 0);
        l = (off == N - 1);
    endtask

    initial begin
        exp_t tab[$];
        exp_t t;
        int   nval;
        int   nerr;
        bit   ev, ef, el;
        int   es;

        tab.push_back('{0,            0, 0,            0, 0, 0});
        tab.push_back('{3 + CPX,      0, 0,            0, 0, 0});
        tab.push_back('{4 + CPX,      1, 4 + CPX,      1, 0, 0});
        tab.push_back('{19 + CPX,     1, 19 + CPX,     0, 1, 0});
        tab.push_back('{20 + CPX,     0, 0,            0, 0, 0});
        tab.push_back('{24 + CPX,     1, 24 + CPX,     1, 0, 1});
        tab.push_back('{39 + CPX,     1, 39 + CPX,     0, 1, 1});
        tab.push_back('{139 + CPX,    1, 139 + CPX,    0, 1, 6});
        tab.push_back('{H,            0, 0,            0, 0, 0});
        tab.push_back('{H + 4 + CPX,  1, H + 4 + CPX,  1, 0, 0});
        tab.push_back('{H + 19 + CPX, 1, H + 19 + CPX, 0, 1, 0});

        // reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(valid_out), 0);
        chk("reset_dout",  int'(dout), 0);
        chk("reset_flags", int'({first_out, last_out, sync_err}), 0);
        chk("reset_sym",   int'(sym_idx), 0);
        rst = 1'b1;

        // continuous ramp, sof at 0 and at the half-subframe boundary
        nval = 0;
        nerr = 0;
        for (int d = 0; d < 160; d++) begin
            step(1'b1, (d == 0) || (d == H), 16'(d));
            record(d);
            nval += lv[d];
            nerr += le[d];
        end
        foreach (tab[i]) begin
            t = tab[i];
            chk($sformatf("cont_valid@%0d", t.d), lv[t.d], int'(t.v));
            chk($sformatf("cont_first@%0d", t.d), lf[t.d], int'(t.f));
            chk($sformatf("cont_last@%0d", t.d),  ll[t.d], int'(t.l));
            if (t.v) begin
                chk($sformatf("cont_dout@%0d", t.d), ld[t.d], t.dout);
                chk($sformatf("cont_sym@%0d", t.d),  ls[t.d], t.s);
            end
        end
        chk("cont_nvalid", nval, 128 - 2 * CPX);
        chk("cont_nerr", nerr, 0);

        // valid_in toggling; a stray sof on an idle cycle must be ignored
        do_reset();
        for (int d = 0; d < 50; d++) begin
            step(1'b1, d == 0, 16'(d));
            exp_of(d, ev, ef, el, es);
            chk($sformatf("tog_valid@%0d", d), int'(valid_out), int'(ev));
            chk($sformatf("tog_first@%0d", d), int'(first_out), int'(ef));
            chk($sformatf("tog_last@%0d", d),  int'(last_out), int'(el));
            chk($sformatf("tog_err@%0d", d),   int'(sync_err), 0);
            if (ev) begin
                chk($sformatf("tog_dout@%0d", d), int'(dout), d);
                chk($sformatf("tog_sym@%0d", d),  int'(sym_idx), es);
            end
            step(1'b0, d == 30, 16'hBEEF);
            chk($sformatf("tog_gap@%0d", d), int'({valid_out, first_out, last_out, sync_err}), 0);
        end

        // extra sof mid-PASS truncates the symbol and resyncs
        do_reset();
        for (int d = 0; d < 40; d++) begin
            step(1'b1, (d == 0) || (d == 10), 16'(d));
            record(d);
        end
        chk("resync_v9",      lv[9], 1);
        chk("resync_d9",      ld[9], 9);
        chk("resync_l9",      ll[9], 0);
        chk("resync_err9",    le[9], 0);
        chk("resync_err10",   le[10], 1);
        chk("resync_v10",     lv[10], 0);
        chk("resync_err11",   le[11], 0);
        chk("resync_vcp",     lv[13 + CPX], 0);
        chk("resync_first",   lf[14 + CPX], 1);
        chk("resync_dfirst",  ld[14 + CPX], 14 + CPX);
        chk("resync_sym",     ls[14 + CPX], 0);
        chk("resync_last",    ll[29 + CPX], 1);
        chk("resync_dlast",   ld[29 + CPX], 29 + CPX);

        // reset asserted mid-PASS, released, sof five samples later
        do_reset();
        for (int d = 0; d < 8; d++) step(1'b1, d == 0, 16'(d));
        chk("prst_pass_valid", int'(valid_out), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("prst_async", int'({dout, valid_out, first_out, last_out, sym_idx, sync_err}), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i == 1, 16'(100 + i));
            chk($sformatf("prst_held%0d", i), int'({dout, valid_out, first_out, last_out, sym_idx, sync_err}), 0);
        end
        rst = 1'b1;
        for (int d = 200; d < 205 + CP + CPX + 2; d++) begin
            step(1'b1, d == 205, 16'(d));
            if (d < 209 + CPX) begin
                chk($sformatf("prst_quiet@%0d", d),
                    int'({dout, valid_out, first_out, last_out, sym_idx, sync_err}), 0);
            end else if (d == 209 + CPX) begin
                chk("prst_first_v", int'(valid_out), 1);
                chk("prst_first_f", int'(first_out), 1);
                chk("prst_first_d", int'(dout), d);
                chk("prst_first_s", int'(sym_idx), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
